w8_rotator: RTL
===============

// Module: w8_rotator
// PURPOSE
//  Pipelined rotator by W8^k = exp(-j*2*pi*k/8); fed by the first radix-8 butterfly stage of the FFT64 core.
//  k = input sample index mod 8 within a 64-sample frame, counted from START.
//  INV=1 applies the conjugate twiddle (IFFT direction).
//  Odd k uses a shift-add 0.7071 multiplier; even k uses swap/negate only.
// PARAMETERS
//  nb        16  data width; complex inputs are nb+2 bits signed (codebase convention)
//  HIGH_PREC 0   0: 0.7071 ~ 0.10110101; 1: 0.10110101000000101 (tracks USFFT64bitwidth_0707_high)
// PORTS
//  CLK    in   1     clock, all logic on rising edge
//  RST    in   1     synchronous, active-low reset
//  ED     in   1     data enable; pipeline and counter advance only when ED=1
//  START  in   1     with ED=1: current sample is index 0 of a new frame
//  INV    in   1     direction, sampled per sample alongside data
//  DR,DI  in   nb+2  signed real/imag input
//  DOR,DOI out nb+3  signed real/imag rotated output
//  RDY    out  1     one-cycle pulse when output index 0 of a frame is on DOR/DOI
// BEHAVIOUR
//  Reset (RST=0 at edge): DOR=DOI=0, RDY=0, sample counter=0, all pipe regs=0, frame-active flag=0.
//  Counter: 6-bit cnt; on ED&START cnt<=1 (sample tagged index 0); else on ED cnt<=cnt+1, wraps 63->0.
//   k = tag[2:0]; effective ke = INV ? (8-k)&7 : k.
//  START mid-frame: restart at index 0 at once; in-flight samples complete with their old k.
//  ED=0: all registers hold, including RDY. A RDY already high stays high until the next ED=1 cycle.
//  Stage 1 (on ED): register a=DR, b=DI, sign-extended to nb+3 bits, then form by ke:
//   0:(a,b)  2:(b,-a)  4:(-a,-b)  6:(-b,a)  [even: bypass, flag skip-mul]
//   1:(a+b,b-a)  3:(b-a,-a-b)  5:(-a-b,a-b)  7:(a-b,a+b)  [odd: to multiplier]
//  Stage 2 (on ED): odd -> each component times 0.7071 via shift-add.
//   181/256, or with HIGH_PREC the 17-bit constant.
//   Result: arithmetic shift right (floor), no rounding.
//   Even -> the value is delayed one stage unchanged.
//  Stage 3 (on ED): output register DOR/DOI.
//  Latency: 3 ED-qualified cycles from input sample to output.
//  RDY: the index-0 tag travels with its sample. RDY=1 on the ED cycle in which the index-0 sample reaches DOR/DOI.
//   RDY never asserts before the first START after reset.
//  Width: nb+3 bits hold -(-2^(nb+1)) and |a+b|*0.7071 without wrap. No saturation needed; no overflow allowed.
//  Reset mid-frame: clears everything. Outputs are valid again only after a new START.
// STRUCTURE
//  Shared pkg/include (FFT64 config): nb default, HIGH_PREC macro, 0.7071 constant bit patterns, ke mapping table.
//  Sub-module: csd_mul_0707 (one per component, 2 instances).
//   Combinational shift-add x*0.7071 on nb+3 bits; stage-2 regs stay in w8_rotator.
//  Top: counter, tag/INV/skip pipeline, swap-negate mux, output regs.
// TESTING
//  1. Reset: RST=0 3 cycles with random inputs -> DOR=DOI=0, RDY=0.
//     After release with no START -> RDY stays 0.
//  2. Forward, nb=16: START+ED, 8 samples DR=1000, DI=0, ED held 1.
//     Outputs 3 cycles later, k0..7: (1000,0) (707,-708) (0,-1000) (-708,-708) (-1000,0) (-708,707) (0,1000) (707,707).
//     RDY exactly on k0.
//  3. INV=1, same stimulus -> conjugates of scenario 2 before scaling.
//     k1 gives (707,707); k2 gives (0,1000).
//  4. ED gaps: ED toggles 1,0,0,1... -> same output sequence as scenario 2.
//     Output changes only on ED cycles; RDY held through ED=0 gaps.
//  5. Extremes: DR=DI=-2^17, k=3, forward -> DOR=0, DOI=floor(2^18*181/256)=185344.
//     k=4 -> (131072,131072); no wrap.
//  6. START at index 37 and RST pulse at index 20 (separate runs).
//     START: index restarts, RDY 3 ED-cycles later, the in-flight 3 samples keep their old k.
//     RST: outputs zero, no RDY until the next START.

Source files
------------

// File: rtl/w8_rotator_pkg.sv
// Shared FFT64 rotator configuration.
// Default widths, 0.7071 bit patterns and the twiddle index mapping.
package w8_rotator_pkg;

    localparam int NB_DEF        = 16;
    localparam int HIGH_PREC_DEF = 0;

    localparam logic [7:0]  C0707_LO = 8'b10110101;
    localparam logic [16:0] C0707_HI = 17'b10110101000000101;

    typedef logic [2:0] ke_t;

    // Inverse direction uses the conjugate twiddle, i.e. index -k mod 8.
    function automatic ke_t ke_map(input logic [2:0] k, input logic inv);
        return inv ? ke_t'(3'd0 - k) : k;
    endfunction

endpackage

// File: rtl/csd_mul_0707.sv
// Combinational shift-add multiply by 0.7071.
// Full-precision sum of shifted terms, then floor shift with no rounding.
module csd_mul_0707
    import w8_rotator_pkg::*;
#(
    parameter int WI        = 20,
    parameter int WO        = 19,
    parameter int HIGH_PREC = 0
) (
    input  logic signed [WI-1:0] x,
    output logic signed [WO-1:0] y
);

    localparam int FB = (HIGH_PREC != 0) ? 17 : 8;
    localparam int WP = WI + FB;
    localparam logic [16:0] C =
        (HIGH_PREC != 0) ? C0707_HI : 17'(C0707_LO);

    logic signed [WP-1:0] xe;
    logic signed [WP-1:0] acc;

    assign xe = {{FB{x[WI-1]}}, x};

    always_comb begin
        acc = '0;
        for (int i = 0; i < FB; i++) begin
            if (C[i]) acc = acc + (xe <<< i);
        end
    end

    assign y = WO'(acc >>> FB);

endmodule

// File: rtl/w8_rotator.sv
// Three-stage W8^k rotator following the first radix-8 FFT64 butterfly.
// Even k is swap/negate only; odd k goes through the 0.7071 multipliers.
module w8_rotator
    import w8_rotator_pkg::*;
#(
    parameter int nb        = NB_DEF,
    parameter int HIGH_PREC = HIGH_PREC_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ED,
    input  logic                START,
    input  logic                INV,
    input  logic signed [nb+1:0] DR,
    input  logic signed [nb+1:0] DI,
    output logic signed [nb+2:0] DOR,
    output logic signed [nb+2:0] DOI,
    output logic                RDY
);

    localparam int WO = nb + 3;
    localparam int WS = nb + 4;

    logic [5:0] cnt;
    logic       active;

    logic             tag0;
    ke_t              ke;
    logic signed [WS-1:0] a, b, fr, fi;

    logic signed [WS-1:0] s1r, s1i;
    logic             s1odd, s1rdy;

    logic signed [WO-1:0] mr, mi;
    logic signed [WO-1:0] s2r, s2i;
    logic             s2rdy;

    assign tag0 = START | (active & (cnt == 6'd0));
    assign ke   = ke_map(START ? 3'd0 : cnt[2:0], INV);
    assign a    = {{2{DR[nb+1]}}, DR};
    assign b    = {{2{DI[nb+1]}}, DI};

    // Odd indices pre-rotate and fold the (1-j) factor before scaling.
    always_comb begin
        fr = a;
        fi = b;
        unique case (ke)
            3'd0: begin fr = a;      fi = b;      end
            3'd1: begin fr = a + b;  fi = b - a;  end
            3'd2: begin fr = b;      fi = -a;     end
            3'd3: begin fr = b - a;  fi = -a - b; end
            3'd4: begin fr = -a;     fi = -b;     end
            3'd5: begin fr = -a - b; fi = a - b;  end
            3'd6: begin fr = -b;     fi = a;      end
            3'd7: begin fr = a - b;  fi = a + b;  end
        endcase
    end

    csd_mul_0707 #(
        .WI(WS), .WO(WO), .HIGH_PREC(HIGH_PREC)
    ) u_mul_re (
        .x(s1r), .y(mr)
    );

    csd_mul_0707 #(
        .WI(WS), .WO(WO), .HIGH_PREC(HIGH_PREC)
    ) u_mul_im (
        .x(s1i), .y(mi)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt    <= '0;
            active <= 1'b0;
            s1r    <= '0;
            s1i    <= '0;
            s1odd  <= 1'b0;
            s1rdy  <= 1'b0;
            s2r    <= '0;
            s2i    <= '0;
            s2rdy  <= 1'b0;
            DOR    <= '0;
            DOI    <= '0;
            RDY    <= 1'b0;
        end else if (ED) begin
            if (START) begin
                cnt    <= 6'd1;
                active <= 1'b1;
            end else begin
                cnt <= cnt + 6'd1;
            end
            s1r   <= fr;
            s1i   <= fi;
            s1odd <= ke[0];
            s1rdy <= tag0;
            s2r   <= s1odd ? mr : WO'(s1r);
            s2i   <= s1odd ? mi : WO'(s1i);
            s2rdy <= s1rdy;
            DOR   <= s2r;
            DOI   <= s2i;
            RDY   <= s2rdy;
        end
    end

endmodule
